barrel_shift_pipe: RTL and testbench
====================================

Name: barrel_shift_pipe

Overview:
Parametrised, pipelined logarithmic barrel shifter with four shift modes and a valid/ready stream interface. It generalises the fixed 8-bit registered left shift to any power-of-two width, variable shift amount, right/arithmetic/rotate modes and backpressure. Shifting is built only from concatenation and muxing; no shift operators are used. It sits in the datapath between a producer and a consumer stream.

Parameters:
WIDTH, 8, data width; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable)
STAGES, $clog2(WIDTH), pipeline depth = latency (derived localparam)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  input beat present
in_ready  output  1  block accepts beat this cycle
data_in  input  WIDTH  operand
shamt  input  SHW  shift amount, 0..WIDTH-1
mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
q_out  output  WIDTH  shifted result
zero  output  1  q_out == 0, aligned with out_valid

Behaviour:
- Single clock. Reset is asynchronous and active-low: clk and reset_n.
- Reset (asserted at any time, including mid-stream): all stage valid bits = 0, all stage data/mode/shamt = 0, so out_valid=0, q_out=0, zero=0 immediately (no clock required). In-flight beats are discarded.
- Pipeline: STAGES registered stages. Stage k (k=0..STAGES-1) applies a distance of 2^k when the carried shamt[k]=1, otherwise passes through. Each stage carries {valid, data, mode, shamt}.
- Stage k modes:
  - LSL: drop the top 2^k bits and zero-fill the bottom.
  - LSR: zero-fill the top.
  - ASR: fill the top with the data MSB as seen at stage k's input, so sign is preserved across stages.
  - ROL: bits shifted out of the top re-enter at the bottom.
- Handshake, global stall: advance = !out_valid || out_ready; in_ready = advance (combinational).
  - Beat accepted on a rising edge with in_valid && in_ready.
  - When advance=1, every stage loads from its predecessor. Stage 0 loads valid=in_valid.
  - When advance=0, all stages hold.
- Latency: a result appears on q_out with out_valid=1 exactly STAGES edges after acceptance, assuming no stall. Throughput is 1 beat/cycle when out_ready=1.
- Bubbles: invalid stage entries still advance, so empty slots collapse only at output; no bubble squeezing.
- Output stability: while out_valid=1 and out_ready=0, q_out and zero are held constant.
- Boundaries:
  - shamt=0 passes data through unchanged in every mode.
  - shamt=WIDTH-1 is the maximum; there is no out-of-range value.
  - in_valid with in_ready=0: the beat is not taken, and the producer must hold it.
  - Simultaneous output pop and input push when full: both occur in the same cycle.
- zero is registered as part of the final stage, not combinational on q_out.

Decomposition:
- Package barrel_shift_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {SH_LSL, SH_LSR, SH_ASR, SH_ROL};
  - function is_pow2 for the WIDTH elaboration check.
- Sub-module bs_stage (parameters WIDTH, DIST) holds one combinational shift level plus its register. It takes advance, valid/data/mode/shamt in and out, and clk/reset_n.
- Top level holds a generate loop over STAGES instances, the handshake logic and zero generation.
- Elaboration error if WIDTH is not a power of two or WIDTH < 4.

Test Plan:
1. WIDTH=8, out_ready=1; 0x96 with LSL by 1, LSR by 3, ASR by 3 and ROL by 3, back-to-back → q_out = 0x2C, 0x12, 0xF2, 0xB4 on 4 consecutive cycles. The first result arrives 3 edges after acceptance.
2. data_in=0xA5, shamt=0, each mode → q_out=0xA5 in all four modes. Then data_in=0x01, LSR by 1 → q_out=0x00 with zero=1.
3. out_ready=0, in_valid=1 held for 6 cycles → exactly 3 beats accepted, then in_ready=0; q_out stays on the first result. Raising out_ready drains all beats in order, one per cycle, with none lost or duplicated.
4. Reset pulse low mid-stream with 3 beats in flight → out_valid=0 and q_out=0 asynchronously, before the next edge. After release, the first new beat emerges after 3 edges.
5. Random stream of 1000 beats, random mode/shamt/data, out_ready toggled randomly → every result matches the scoreboard model (multiply/divide-by-2^n reference for shifts, concatenation for ROL) in order.
6. WIDTH=32 instance; 0x8000_0001 with ASR by 31 → 0xFFFF_FFFF; with ROL by 31 → 0xC000_0000; latency is 5 cycles.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROL = 2'b11
  } shift_mode_t;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bs_stage.sv
// One logarithmic shift level (fixed distance DIST, enabled by shamt bit log2(DIST))
// followed by its pipeline register, plus a registered all-zero flag.
module bs_stage
  import barrel_shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DIST  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_advance,
  input  logic              i_valid,
  input  logic [WIDTH-1:0]  i_data,
  input  shift_mode_t       i_mode,
  input  logic [SHW-1:0]    i_shamt,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_data,
  output shift_mode_t       o_mode,
  output logic [SHW-1:0]    o_shamt,
  output logic              o_zero
);

  localparam int SEL = $clog2(DIST);

  logic [WIDTH-1:0] w_shifted;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  shift_mode_t      r_mode;
  logic [SHW-1:0]   r_shamt;
  logic             r_zero;

  // ASR fills with the MSB seen at this level, so sign survives earlier levels.
  always_comb begin
    w_shifted = i_data;
    if (i_shamt[SEL]) begin
      case (i_mode)
        SH_LSL:  w_shifted = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SH_LSR:  w_shifted = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
        SH_ASR:  w_shifted = {{DIST{i_data[WIDTH-1]}}, i_data[WIDTH-1:DIST]};
        SH_ROL:  w_shifted = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
        default: w_shifted = i_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= SH_LSL;
      r_shamt <= '0;
      r_zero  <= 1'b0;
    end else if (i_advance) begin
      r_valid <= i_valid;
      r_data  <= w_shifted;
      r_mode  <= i_mode;
      r_shamt <= i_shamt;
      r_zero  <= i_valid && (w_shifted == '0);
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;
  assign o_shamt = r_shamt;
  assign o_zero  = r_zero;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined log2(WIDTH)-stage barrel shifter (LSL/LSR/ASR/ROL) with a
// globally stalled valid/ready stream interface.
module barrel_shift_pipe
  import barrel_shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q_out,
  output logic             zero
);

  localparam int STAGES = $clog2(WIDTH);

  if (!is_pow2(WIDTH) || (WIDTH < 4)) begin : g_bad_width
    $error("barrel_shift_pipe: WIDTH must be a power of two and at least 4");
  end

  logic             w_advance;
  logic             w_valid [0:STAGES];
  logic [WIDTH-1:0] w_data  [0:STAGES];
  shift_mode_t      w_mode  [0:STAGES];
  logic [SHW-1:0]   w_shamt [0:STAGES];
  logic             w_zero  [0:STAGES-1];

  // Whole pipeline moves together; bubbles travel with it to the output.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = data_in;
  assign w_mode[0]  = shift_mode_t'(mode);
  assign w_shamt[0] = shamt;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      bs_stage #(
        .WIDTH (WIDTH),
        .DIST  (2 ** gi)
      ) u_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_advance (w_advance),
        .i_valid   (w_valid[gi]),
        .i_data    (w_data[gi]),
        .i_mode    (w_mode[gi]),
        .i_shamt   (w_shamt[gi]),
        .o_valid   (w_valid[gi+1]),
        .o_data    (w_data[gi+1]),
        .o_mode    (w_mode[gi+1]),
        .o_shamt   (w_shamt[gi+1]),
        .o_zero    (w_zero[gi])
      );
    end
  endgenerate

  assign out_valid = w_valid[STAGES];
  assign q_out     = w_data[STAGES];
  assign zero      = w_zero[STAGES-1];

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed and randomized checks of barrel_shift_pipe at WIDTH=8 and WIDTH=32.
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, zero;
  logic [7:0] data_in, q_out;
  logic [2:0] shamt;
  logic [1:0] mode;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_zero;
  logic [31:0] w_data_in, w_q_out;
  logic [4:0]  w_shamt;
  logic [1:0]  w_mode;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] v_data [8];
  logic [4:0]  v_sh   [8];
  logic [1:0]  v_mode [8];
  logic [31:0] v_exp  [8];
  logic        v_zero [8];

  barrel_shift_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .q_out(q_out), .zero(zero)
  );

  barrel_shift_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .data_in(w_data_in), .shamt(w_shamt), .mode(w_mode), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .q_out(w_q_out), .zero(w_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: arithmetic for shifts, concatenation for rotate.
  function automatic logic [7:0] model8(input logic [7:0] d, input int s, input logic [1:0] m);
    int p, sv, r;
    logic [15:0] dd;
    p  = 1 << s;
    dd = {d, d};
    case (m)
      2'd0: r = (int'(d) * p) % 256;
      2'd1: r = int'(d) / p;
      2'd2: begin
        sv = d[7] ? int'(d) - 256 : int'(d);
        r  = (sv >= 0) ? sv / p : -((-sv + p - 1) / p);
      end
      default: r = int'(dd[15-s -: 8]);
    endcase
    return r[7:0];
  endfunction

  // Push n beats from the v_* tables back to back with out_ready=1; check each
  // result arrives exactly lat edges after its acceptance edge.
  task automatic run_seq(input string name, input bit wide, input int n);
    int lat, idx;
    logic ov, zz;
    logic [31:0] qq;
    lat = wide ? 5 : 3;
    for (int i = 0; i < n + lat; i++) begin
      if (wide) begin
        w_in_valid = (i < n);
        if (i < n) begin w_data_in = v_data[i]; w_shamt = v_sh[i]; w_mode = v_mode[i]; end
      end else begin
        in_valid = (i < n);
        if (i < n) begin data_in = v_data[i][7:0]; shamt = v_sh[i][2:0]; mode = v_mode[i]; end
      end
      @(posedge clk); #1;
      ov  = wide ? w_out_valid : out_valid;
      qq  = wide ? w_q_out : {24'h0, q_out};
      zz  = wide ? w_zero : zero;
      idx = i - lat + 1;
      if (idx >= 0 && idx < n) begin
        chk($sformatf("%s_valid[%0d]", name, idx), {31'h0, ov}, 32'd1);
        chk($sformatf("%s_q[%0d]", name, idx), qq, v_exp[idx]);
        chk($sformatf("%s_zero[%0d]", name, idx), {31'h0, zz}, {31'h0, v_zero[idx]});
      end else begin
        chk($sformatf("%s_novalid[%0d]", name, i), {31'h0, ov}, 32'd0);
      end
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] m, input logic [31:0] e);
    v_data[i] = d; v_sh[i] = s; v_mode[i] = m; v_exp[i] = e; v_zero[i] = (e == 32'h0);
  endtask

  initial begin
    logic acc;
    int n_acc, sent, rcvd, cyc;
    logic [7:0] expq[$];
    logic [7:0] e;

    in_valid = 0; data_in = 0; shamt = 0; mode = 0; out_ready = 1;
    w_in_valid = 0; w_data_in = 0; w_shamt = 0; w_mode = 0; w_out_ready = 1;

    #12;
    chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
    chk("reset_q_out", {24'h0, q_out}, 32'h0);
    chk("reset_zero", {31'h0, zero}, 32'd0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'd1);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;

    // Four modes on 0x96, back to back
    set_vec(0, 32'h96, 5'd1, 2'd0, 32'h2C);
    set_vec(1, 32'h96, 5'd3, 2'd1, 32'h12);
    set_vec(2, 32'h96, 5'd3, 2'd2, 32'hF2);
    set_vec(3, 32'h96, 5'd3, 2'd3, 32'hB4);
    run_seq("modes96", 1'b0, 4);

    // shamt=0 passthrough and zero flag
    for (int i = 0; i < 4; i++) set_vec(i, 32'hA5, 5'd0, 2'(i), 32'hA5);
    set_vec(4, 32'h01, 5'd1, 2'd1, 32'h00);
    set_vec(5, 32'h80, 5'd7, 2'd2, 32'hFF);
    set_vec(6, 32'h80, 5'd7, 2'd3, 32'h40);
    run_seq("pass_zero", 1'b0, 7);

    // Backpressure: fill, stall, then drain in order
    out_ready = 0; in_valid = 1; data_in = 8'h11; shamt = 3'd1; mode = 2'd0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin n_acc++; data_in = data_in + 8'h11; end
      if (out_valid) chk($sformatf("stall_hold[%0d]", c), {24'h0, q_out}, 32'h22);
    end
    chk("stall_accepted", 32'(n_acc), 32'd3);
    chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
    in_valid = 0; out_ready = 1; #1;
    chk("drain_q0", {24'h0, q_out}, 32'h22);
    @(posedge clk); #1;
    chk("drain_v1", {31'h0, out_valid}, 32'd1);
    chk("drain_q1", {24'h0, q_out}, 32'h44);
    @(posedge clk); #1;
    chk("drain_v2", {31'h0, out_valid}, 32'd1);
    chk("drain_q2", {24'h0, q_out}, 32'h66);
    @(posedge clk); #1;
    chk("drain_empty", {31'h0, out_valid}, 32'd0);

    // Asynchronous reset with beats in flight
    in_valid = 1; data_in = 8'h3C; shamt = 3'd2; mode = 2'd0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    in_valid = 0;
    chk("pre_reset_valid", {31'h0, out_valid}, 32'd1);
    #2 reset_n = 0;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 32'd0);
    chk("async_rst_q", {24'h0, q_out}, 32'h0);
    chk("async_rst_zero", {31'h0, zero}, 32'd0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    set_vec(0, 32'h0F, 5'd4, 2'd1, 32'h00);
    run_seq("post_reset", 1'b0, 1);

    // Random stream against the model with random backpressure
    sent = 0; rcvd = 0; cyc = 0; in_valid = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1;
        data_in  = 8'($urandom_range(0, 255));
        shamt    = 3'($urandom_range(0, 7));
        mode     = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("rand_unexpected", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk($sformatf("rand_q[%0d]", rcvd), {24'h0, q_out}, {24'h0, e});
          chk($sformatf("rand_zero[%0d]", rcvd), {31'h0, zero}, {31'h0, (e == 8'h0)});
        end
        rcvd++;
      end
      acc = in_valid && in_ready;
      if (acc) begin expq.push_back(model8(data_in, int'(shamt), mode)); sent++; end
      @(posedge clk); #1;
      cyc++;
      if (acc) in_valid = 0;
    end
    chk("rand_received", 32'(rcvd), 32'd1000);
    in_valid = 0; out_ready = 1;

    // 32-bit instance
    set_vec(0, 32'h8000_0001, 5'd31, 2'd2, 32'hFFFF_FFFF);
    set_vec(1, 32'h8000_0001, 5'd31, 2'd3, 32'hC000_0000);
    set_vec(2, 32'h8000_0001, 5'd31, 2'd1, 32'h0000_0001);
    set_vec(3, 32'h8000_0001, 5'd1,  2'd0, 32'h0000_0002);
    run_seq("w32", 1'b1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
